// File: rtl/csr_mc.sv
// csr_mc: register block for a pulser/acquisition controller, with a read-through port to external RAM.
// Latency: register reads give csr_rvalid 2 cycles after csr_ren; RAMDATA reads wait for ramctl_rvalid or RD_TIMEOUT.
// Backpressure: none. The master holds csr_ren until csr_rvalid; csr_ren is then ignored for one cycle.
// Ports: clk/rst (async active-low assert, two-flop synchronous release); csr_* register bus;
//   ramctl_* RAM read port; pulser_*/ch_en pulser config; dac_gain_ptr/dac_gain gain lookup;
//   acq_* acquisition control; led = {|ch_en, rd_timeout_err, acquisition running}.
// Optional feature: define CSR_MC_EXT_START_EN to accept acq_start_ext through a synchroniser.
module csr_mc #(
  parameter int CSR_ADDR_W   = 8,
  parameter int CSR_DATA_W   = 16,
  parameter int RAM_ADDR_W   = 19,
  parameter int RAM_DATA_W   = 16,
  parameter int CH_N         = 2,
  parameter int PULSER_LEN_W = 8,
  parameter int DAC_DATA_W   = 10,
  parameter int DAC_GAIN_N   = 32,
  parameter int ACQ_LINES_W  = 5,
  parameter int RD_TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CSR_ADDR_W-1:0]          csr_addr,
  input  logic                           csr_wen,
  input  logic [CSR_DATA_W-1:0]          csr_wdata,
  input  logic                           csr_ren,
  output logic                           csr_rvalid,
  output logic [CSR_DATA_W-1:0]          csr_rdata,
  output logic [RAM_ADDR_W-1:0]          ramctl_raddr,
  output logic                           ramctl_ren,
  input  logic                           ramctl_rvalid,
  input  logic [RAM_DATA_W-1:0]          ramctl_rdata,
  output logic [CH_N*PULSER_LEN_W-1:0]   pulser_on_len,
  output logic [CH_N*PULSER_LEN_W-1:0]   pulser_off_len,
  output logic [CH_N-1:0]                ch_en,
  input  logic [$clog2(DAC_GAIN_N)-1:0]  dac_gain_ptr,
  output logic [DAC_DATA_W-1:0]          dac_gain,
  output logic                           acq_start,
  input  logic                           acq_start_ext,
  input  logic                           acq_done,
  input  logic                           acq_busy,
  output logic [ACQ_LINES_W-1:0]         acq_lines,
  output logic [2:0]                     led
);

  localparam int A_ID       = 'h00;
  localparam int A_CTRL     = 'h01;
  localparam int A_STATUS   = 'h02;
  localparam int A_ACQLINES = 'h03;
  localparam int A_ON       = 'h10;
  localparam int A_OFF      = 'h18;
  localparam int A_GAIN     = 'h20;
  localparam int A_RAMDATA  = 'hA0;
  localparam int A_RSTRAM   = 'hA1;
  localparam int A_ACQSTART = 'hA2;

  localparam int TMR_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(RD_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REG  = 2'd1;
  localparam logic [1:0] ST_RAMW = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  function automatic logic hit(input logic [CSR_ADDR_W-1:0] a, input int v);
    return a == CSR_ADDR_W'(v);
  endfunction

  // Reset asserts immediately but releases only after two clock edges, so
  // every flop below leaves reset on the same edge.
  logic [1:0] rst_pipe;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= 2'b00;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  logic [PULSER_LEN_W-1:0] on_len   [CH_N];
  logic [PULSER_LEN_W-1:0] off_len  [CH_N];
  logic [DAC_DATA_W-1:0]   gain_tbl [DAC_GAIN_N];
  logic [1:0]              state;
  logic [CSR_ADDR_W-1:0]   rd_addr;
  logic [TMR_W-1:0]        timer;
  logic [CSR_DATA_W-1:0]   rd_mux;
  logic                    rd_timeout_err;
  logic                    ext_seen;
  logic                    ext_rise;
  logic                    raddr_rst_pend;
  logic                    led_acq;

  logic wr_status, wr_rstram, wr_acqstart;
  logic ram_done, ram_to;
  logic start_fire;

  assign wr_status   = csr_wen && hit(csr_addr, A_STATUS);
  assign wr_rstram   = csr_wen && hit(csr_addr, A_RSTRAM);
  assign wr_acqstart = csr_wen && hit(csr_addr, A_ACQSTART);

  // A RAM read ends either with data or with the timeout; data wins a tie.
  assign ram_done = (state == ST_RAMW) && ramctl_rvalid;
  assign ram_to   = (state == ST_RAMW) && !ramctl_rvalid && (timer == TO_LAST);

`ifdef CSR_MC_EXT_START_EN
  logic [2:0] ext_sync;
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) ext_sync <= 3'b000;
    else             ext_sync <= {ext_sync[1:0], acq_start_ext};
  end
  assign ext_rise = ext_sync[1] & ~ext_sync[2];
`else
  logic unused_ext;
  assign unused_ext = acq_start_ext;
  assign ext_rise   = 1'b0;
`endif

  // Writable configuration registers; bits above each field width are dropped.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      ch_en     <= '0;
      acq_lines <= '0;
      for (int c = 0; c < CH_N; c++) begin
        on_len[c]  <= '0;
        off_len[c] <= '0;
      end
      for (int g = 0; g < DAC_GAIN_N; g++) gain_tbl[g] <= '0;
    end else if (csr_wen) begin
      if (hit(csr_addr, A_CTRL))     ch_en     <= CH_N'(csr_wdata);
      if (hit(csr_addr, A_ACQLINES)) acq_lines <= ACQ_LINES_W'(csr_wdata);
      for (int c = 0; c < CH_N; c++) begin
        if (hit(csr_addr, A_ON + c))  on_len[c]  <= PULSER_LEN_W'(csr_wdata);
        if (hit(csr_addr, A_OFF + c)) off_len[c] <= PULSER_LEN_W'(csr_wdata);
      end
      for (int g = 0; g < DAC_GAIN_N; g++)
        if (hit(csr_addr, A_GAIN + g)) gain_tbl[g] <= DAC_DATA_W'(csr_wdata);
    end
  end

  for (genvar c = 0; c < CH_N; c++) begin : g_len
    assign pulser_on_len[c*PULSER_LEN_W +: PULSER_LEN_W]  = on_len[c];
    assign pulser_off_len[c*PULSER_LEN_W +: PULSER_LEN_W] = off_len[c];
  end

  // Sticky status bits: a new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rd_timeout_err <= 1'b0;
      ext_seen       <= 1'b0;
    end else begin
      if (ram_to)                        rd_timeout_err <= 1'b1;
      else if (wr_status && csr_wdata[2]) rd_timeout_err <= 1'b0;
      if (ext_rise)                      ext_seen <= 1'b1;
      else if (wr_status && csr_wdata[1]) ext_seen <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (hit(rd_addr, A_ID))       rd_mux = CSR_DATA_W'(16'hC5A2);
    if (hit(rd_addr, A_CTRL))     rd_mux = CSR_DATA_W'(ch_en);
    if (hit(rd_addr, A_STATUS))   rd_mux = CSR_DATA_W'({rd_timeout_err, ext_seen, acq_busy});
    if (hit(rd_addr, A_ACQLINES)) rd_mux = CSR_DATA_W'(acq_lines);
    for (int c = 0; c < CH_N; c++) begin
      if (hit(rd_addr, A_ON + c))  rd_mux = CSR_DATA_W'(on_len[c]);
      if (hit(rd_addr, A_OFF + c)) rd_mux = CSR_DATA_W'(off_len[c]);
    end
    for (int g = 0; g < DAC_GAIN_N; g++)
      if (hit(rd_addr, A_GAIN + g)) rd_mux = CSR_DATA_W'(gain_tbl[g]);
  end

  // Read FSM. HOLD swallows one cycle of csr_ren so a master that drops ren
  // a cycle late does not trigger a second read.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= ST_IDLE;
      rd_addr    <= '0;
      timer      <= '0;
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
      ramctl_ren <= 1'b0;
    end else begin
      csr_rvalid <= 1'b0;
      ramctl_ren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (csr_ren) begin
            rd_addr <= csr_addr;
            timer   <= '0;
            if (hit(csr_addr, A_RAMDATA)) begin
              ramctl_ren <= 1'b1;
              state      <= ST_RAMW;
            end else begin
              state <= ST_REG;
            end
          end
        end
        ST_REG: begin
          csr_rvalid <= 1'b1;
          csr_rdata  <= rd_mux;
          state      <= ST_HOLD;
        end
        ST_RAMW: begin
          if (ramctl_rvalid) begin
            csr_rvalid <= 1'b1;
            csr_rdata  <= CSR_DATA_W'(ramctl_rdata);
            state      <= ST_HOLD;
          end else if (timer == TO_LAST) begin
            csr_rvalid <= 1'b1;
            csr_rdata  <= CSR_DATA_W'(16'hDEAD);
            state      <= ST_HOLD;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM read pointer. A pointer reset requested mid-read is parked until the
  // read finishes so the outstanding RAM access sees a stable address.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      ramctl_raddr   <= '0;
      raddr_rst_pend <= 1'b0;
    end else if (state == ST_RAMW) begin
      if (ram_done || ram_to) begin
        raddr_rst_pend <= 1'b0;
        if (raddr_rst_pend || wr_rstram) ramctl_raddr <= '0;
        else if (ram_done)               ramctl_raddr <= ramctl_raddr + RAM_ADDR_W'(1);
      end else if (wr_rstram) begin
        raddr_rst_pend <= 1'b1;
      end
    end else if (wr_rstram) begin
      ramctl_raddr <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) dac_gain <= '0;
    else if (int'(dac_gain_ptr) < DAC_GAIN_N) dac_gain <= gain_tbl[dac_gain_ptr];
    else dac_gain <= '0;
  end

  // Any start source collapses into one pulse; no pulse while busy or
  // directly after a pulse.
  assign start_fire = ((wr_acqstart && csr_wdata[0]) || ext_rise) && !acq_busy && !acq_start;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      acq_start <= 1'b0;
      led_acq   <= 1'b0;
    end else begin
      acq_start <= start_fire;
      if (start_fire)    led_acq <= 1'b1;
      else if (acq_done) led_acq <= 1'b0;
    end
  end

  assign led = {|ch_en, rd_timeout_err, led_acq};

endmodule

// File: tb/tb_csr_mc.sv
module tb_csr_mc;
  localparam int CSR_ADDR_W   = 8;
  localparam int CSR_DATA_W   = 16;
  localparam int RAM_ADDR_W   = 19;
  localparam int RAM_DATA_W   = 16;
  localparam int CH_N         = 2;
  localparam int PULSER_LEN_W = 8;
  localparam int DAC_DATA_W   = 10;
  localparam int DAC_GAIN_N   = 32;
  localparam int ACQ_LINES_W  = 5;
  localparam int RD_TIMEOUT   = 64;
  localparam int GP_W         = $clog2(DAC_GAIN_N);

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [CSR_ADDR_W-1:0]        csr_addr = '0;
  logic                         csr_wen = 1'b0;
  logic [CSR_DATA_W-1:0]        csr_wdata = '0;
  logic                         csr_ren = 1'b0;
  logic                         csr_rvalid;
  logic [CSR_DATA_W-1:0]        csr_rdata;
  logic [RAM_ADDR_W-1:0]        ramctl_raddr;
  logic                         ramctl_ren;
  logic                         ramctl_rvalid = 1'b0;
  logic [RAM_DATA_W-1:0]        ramctl_rdata = '0;
  logic [CH_N*PULSER_LEN_W-1:0] pulser_on_len;
  logic [CH_N*PULSER_LEN_W-1:0] pulser_off_len;
  logic [CH_N-1:0]              ch_en;
  logic [GP_W-1:0]              dac_gain_ptr = '0;
  logic [DAC_DATA_W-1:0]        dac_gain;
  logic                         acq_start;
  logic                         acq_start_ext = 1'b0;
  logic                         acq_done = 1'b0;
  logic                         acq_busy = 1'b0;
  logic [ACQ_LINES_W-1:0]       acq_lines;
  logic [2:0]                   led;

  csr_mc #(
    .CSR_ADDR_W(CSR_ADDR_W), .CSR_DATA_W(CSR_DATA_W), .RAM_ADDR_W(RAM_ADDR_W),
    .RAM_DATA_W(RAM_DATA_W), .CH_N(CH_N), .PULSER_LEN_W(PULSER_LEN_W),
    .DAC_DATA_W(DAC_DATA_W), .DAC_GAIN_N(DAC_GAIN_N), .ACQ_LINES_W(ACQ_LINES_W),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
    .csr_ren(csr_ren), .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
    .ramctl_raddr(ramctl_raddr), .ramctl_ren(ramctl_ren),
    .ramctl_rvalid(ramctl_rvalid), .ramctl_rdata(ramctl_rdata),
    .pulser_on_len(pulser_on_len), .pulser_off_len(pulser_off_len), .ch_en(ch_en),
    .dac_gain_ptr(dac_gain_ptr), .dac_gain(dac_gain),
    .acq_start(acq_start), .acq_start_ext(acq_start_ext), .acq_done(acq_done),
    .acq_busy(acq_busy), .acq_lines(acq_lines), .led(led)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit ram_on = 1'b1;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [15:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_wen   = 1'b1;
    tick();
    csr_wen   = 1'b0;
  endtask

  // Reads one CSR. lat counts rising edges from the ren sample up to the edge
  // that raises csr_rvalid; ren_lat is the edge count at which ramctl_ren was seen.
  // The RAM model answers 4 cycles after ramctl_ren with raddr + 0x42.
  task automatic csr_read(input logic [7:0] a, output logic [15:0] d, output int lat, output int ren_lat);
    int cnt;
    logic [RAM_ADDR_W-1:0] ra;
    bit done;
    cnt = 0; ra = '0; done = 1'b0; d = '0; lat = 0; ren_lat = -1;
    csr_addr = a;
    csr_ren  = 1'b1;
    while (!done && lat < 300) begin
      tick();
      lat++;
      ramctl_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ramctl_rvalid = 1'b1;
          ramctl_rdata  = 16'(ra) + 16'h0042;
        end
      end
      if (ramctl_ren) begin
        ren_lat = lat;
        if (ram_on) begin
          cnt = 4;
          ra  = ramctl_raddr;
        end
      end
      if (csr_rvalid) begin
        d    = csr_rdata;
        done = 1'b1;
      end
    end
    csr_ren       = 1'b0;
    ramctl_rvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_bound addr=%h got=no csr_rvalid after %0d cycles", a, lat);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", csr_rvalid); end
    checks++; if (csr_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h exp=0000", csr_rdata); end
    checks++; if (ramctl_ren !== 1'b0 || ramctl_raddr !== '0) begin errors++; $display("FAIL rst_ram got ren=%b addr=%h exp 0/0", ramctl_ren, ramctl_raddr); end
    checks++; if (acq_start !== 1'b0 || led !== 3'b000) begin errors++; $display("FAIL rst_acq got start=%b led=%b exp 0/000", acq_start, led); end
    checks++; if (ch_en !== '0 || pulser_on_len !== '0 || pulser_off_len !== '0 || acq_lines !== '0) begin errors++; $display("FAIL rst_cfg got ch_en=%b on=%h off=%h lines=%h exp all 0", ch_en, pulser_on_len, pulser_off_len, acq_lines); end
    checks++; if (dac_gain !== '0) begin errors++; $display("FAIL rst_gain got=%h exp=000", dac_gain); end
  endtask

  task automatic test_id_ctrl();
    logic [15:0] d; int lat, rl;
    csr_read(8'h00, d, lat, rl);
    checks++; if (d !== 16'hC5A2) begin errors++; $display("FAIL id_data got=%h exp=c5a2", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL id_latency got=%0d exp=2", lat); end
    csr_read(8'h01, d, lat, rl);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ctrl_reset got=%h exp=0000", d); end
    csr_write(8'h01, 16'hFFFF);
    checks++; if (ch_en !== 2'b11 || led[2] !== 1'b1) begin errors++; $display("FAIL ctrl_write got ch_en=%b led2=%b exp 11/1", ch_en, led[2]); end
    csr_read(8'h01, d, lat, rl);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL ctrl_trunc got=%h exp=0003", d); end
    csr_write(8'h01, 16'h0000);
    checks++; if (led[2] !== 1'b0) begin errors++; $display("FAIL led2_clear got=%b exp=0", led[2]); end
    csr_write(8'h00, 16'h1234);
    csr_read(8'h00, d, lat, rl);
    checks++; if (d !== 16'hC5A2) begin errors++; $display("FAIL id_readonly got=%h exp=c5a2", d); end
    csr_read(8'h7F, d, lat, rl);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped got=%h exp=0000", d); end
  endtask

  task automatic test_pulser();
    logic [15:0] d; int lat, rl;
    csr_write(8'h10, 16'h12AB);
    csr_write(8'h11, 16'h0034);
    csr_write(8'h18, 16'h0056);
    csr_write(8'h19, 16'hFF78);
    checks++; if (pulser_on_len !== 16'h34AB) begin errors++; $display("FAIL on_len got=%h exp=34ab", pulser_on_len); end
    checks++; if (pulser_off_len !== 16'h7856) begin errors++; $display("FAIL off_len got=%h exp=7856", pulser_off_len); end
    csr_read(8'h10, d, lat, rl);
    checks++; if (d !== 16'h00AB) begin errors++; $display("FAIL on_len_read got=%h exp=00ab", d); end
    csr_write(8'h03, 16'hFFFF);
    checks++; if (acq_lines !== 5'h1F) begin errors++; $display("FAIL acq_lines got=%h exp=1f", acq_lines); end
    csr_read(8'h03, d, lat, rl);
    checks++; if (d !== 16'h001F) begin errors++; $display("FAIL acq_lines_read got=%h exp=001f", d); end
  endtask

  task automatic test_gain();
    logic [15:0] d; int lat, rl;
    csr_write(8'h23, 16'h0233);
    dac_gain_ptr = 5'd3;
    #1;
    checks++; if (dac_gain !== 10'h000) begin errors++; $display("FAIL gain_registered got=%h exp=000", dac_gain); end
    tick();
    checks++; if (dac_gain !== 10'h233) begin errors++; $display("FAIL gain_lookup got=%h exp=233", dac_gain); end
    csr_read(8'h23, d, lat, rl);
    checks++; if (d !== 16'h0233) begin errors++; $display("FAIL gain_read got=%h exp=0233", d); end
    csr_write(8'h3F, 16'hFFFF);
    dac_gain_ptr = 5'd31;
    tick();
    checks++; if (dac_gain !== 10'h3FF) begin errors++; $display("FAIL gain_last got=%h exp=3ff", dac_gain); end
    csr_read(8'h40, d, lat, rl);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL gain_past_end got=%h exp=0000", d); end
    dac_gain_ptr = 5'd0;
  endtask

  task automatic test_ram_read();
    logic [15:0] d; int lat, rl;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'h0042; exp_d[1] = 16'h0043; exp_d[2] = 16'h0044;
    ram_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      csr_read(8'hA0, d, lat, rl);
      checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL ram_read%0d got=%h exp=%h", i, d, exp_d[i]); end
    end
    checks++; if (ramctl_raddr !== 19'd3) begin errors++; $display("FAIL ram_addr_inc got=%0d exp=3", ramctl_raddr); end
    csr_write(8'hA1, 16'h0001);
    checks++; if (ramctl_raddr !== 19'd0) begin errors++; $display("FAIL ram_addr_rst got=%0d exp=0", ramctl_raddr); end
    csr_read(8'hA0, d, lat, rl);
    checks++; if (d !== 16'h0042) begin errors++; $display("FAIL ram_after_rst got=%h exp=0042", d); end
  endtask

  task automatic test_timeout();
    logic [15:0] d; int lat, rl;
    ram_on = 1'b0;
    csr_read(8'hA0, d, lat, rl);
    checks++; if (d !== 16'hDEAD) begin errors++; $display("FAIL to_data got=%h exp=dead", d); end
    checks++; if (lat - rl !== RD_TIMEOUT) begin errors++; $display("FAIL to_cycles got=%0d exp=%0d", lat - rl, RD_TIMEOUT); end
    checks++; if (ramctl_raddr !== 19'd1) begin errors++; $display("FAIL to_addr_kept got=%0d exp=1", ramctl_raddr); end
    checks++; if (led[1] !== 1'b1) begin errors++; $display("FAIL to_led1 got=%b exp=1", led[1]); end
    csr_read(8'h02, d, lat, rl);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL to_status got=%h exp=0004", d); end
    csr_write(8'h02, 16'h0004);
    csr_read(8'h02, d, lat, rl);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL status_clear got=%h exp=0000", d); end
    ram_on = 1'b1;
  endtask

  // Master keeps ren high one cycle past csr_rvalid: exactly one rvalid expected.
  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    csr_addr = 8'h00;
    csr_ren  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (csr_rvalid) pulses++;
      if (i == 2) csr_ren = 1'b0;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL late_release_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_acq_start();
    logic [15:0] d; int lat, rl;
    csr_write(8'hA2, 16'h0001);
    checks++; if (acq_start !== 1'b1 || led[0] !== 1'b1) begin errors++; $display("FAIL start_write got start=%b led0=%b exp 1/1", acq_start, led[0]); end
    tick();
    checks++; if (acq_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got=%b exp=0", acq_start); end
    csr_addr = 8'hA2; csr_wdata = 16'h0001; csr_wen = 1'b1;
    tick();
    tick();
    csr_wen = 1'b0;
    checks++; if (acq_start !== 1'b0) begin errors++; $display("FAIL start_back_to_back got=%b exp=0", acq_start); end
    acq_busy = 1'b1;
    csr_write(8'hA2, 16'h0001);
    checks++; if (acq_start !== 1'b0) begin errors++; $display("FAIL start_busy got=%b exp=0", acq_start); end
    csr_read(8'h02, d, lat, rl);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL status_busy got=%h exp=0001", d); end
    acq_done = 1'b1; tick(); acq_done = 1'b0;
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL done_clears_led got=%b exp=0", led[0]); end
    acq_busy = 1'b0;
    csr_write(8'hA2, 16'h0000);
    checks++; if (acq_start !== 1'b0) begin errors++; $display("FAIL start_bit0_zero got=%b exp=0", acq_start); end
    acq_done = 1'b1;
    csr_write(8'hA2, 16'h0001);
    acq_done = 1'b0;
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL led_set_wins got=%b exp=1", led[0]); end
    acq_done = 1'b1; tick(); acq_done = 1'b0;
  endtask

  task automatic test_ext_start();
    logic [15:0] d; int lat, rl;
    logic [2:0] seq;
    int extra;
    seq = 3'b000;
    acq_start_ext = 1'b1; tick(); acq_start_ext = 1'b0;
    seq[0] = acq_start;
    tick(); seq[1] = acq_start;
    tick(); seq[2] = acq_start;
`ifdef CSR_MC_EXT_START_EN
    checks++; if (seq !== 3'b100) begin errors++; $display("FAIL ext_start_timing got=%b exp=100", seq); end
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL ext_led0 got=%b exp=1", led[0]); end
    csr_read(8'h02, d, lat, rl);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL ext_seen got=%h exp=0002", d); end
    acq_busy = 1'b1;
    acq_start_ext = 1'b1; tick(); acq_start_ext = 1'b0;
    extra = 0;
    repeat (5) begin tick(); if (acq_start) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ext_while_busy got=%0d pulses exp=0", extra); end
    acq_done = 1'b1; tick(); acq_done = 1'b0;
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL ext_done_led0 got=%b exp=0", led[0]); end
    acq_busy = 1'b0;
`else
    extra = 0;
    repeat (3) begin tick(); if (acq_start) extra++; end
    checks++; if (seq !== 3'b000 || extra !== 0) begin errors++; $display("FAIL ext_ignored got seq=%b extra=%0d exp 000/0", seq, extra); end
    csr_read(8'h02, d, lat, rl);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ext_seen_off got=%h exp=0000", d); end
`endif
  endtask

  task automatic test_reset_in_ramw();
    logic [15:0] d; int lat, rl;
    int pulses;
    ram_on = 1'b0;
    csr_addr = 8'hA0;
    csr_ren  = 1'b1;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    checks++; if (csr_rvalid !== 1'b0 || ramctl_raddr !== '0 || ch_en !== '0) begin errors++; $display("FAIL async_reset got rvalid=%b raddr=%0d ch_en=%b exp 0/0/0", csr_rvalid, ramctl_raddr, ch_en); end
    csr_ren = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();
    ramctl_rvalid = 1'b1; ramctl_rdata = 16'h1234;
    tick();
    ramctl_rvalid = 1'b0;
    pulses = 0;
    repeat (4) begin if (csr_rvalid) pulses++; tick(); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL late_rvalid_ignored got=%0d pulses exp=0", pulses); end
    ram_on = 1'b1;
    csr_read(8'h00, d, lat, rl);
    checks++; if (d !== 16'hC5A2 || lat !== 2) begin errors++; $display("FAIL after_abort got data=%h lat=%0d exp c5a2/2", d, lat); end
    csr_read(8'hA0, d, lat, rl);
    checks++; if (d !== 16'h0042) begin errors++; $display("FAIL ram_after_abort got=%h exp=0042", d); end
  endtask

  initial begin
    test_reset();
    test_id_ctrl();
    test_pulser();
    test_gain();
    test_ram_read();
    test_timeout();
    test_back_to_back();
    test_acq_start();
    test_ext_start();
    test_reset_in_ramw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_mc.md
CSR_MC -- requirements
Module: csr_mc

Interface
REQ-001 SHALL have parameter CSR_ADDR_W, default 8, CSR address width.
REQ-002 SHALL have parameter CSR_DATA_W, default 16, CSR data width.
REQ-003 SHALL have parameters RAM_ADDR_W, default 19, and RAM_DATA_W, default 16, external RAM read bus widths.
REQ-004 SHALL have parameter CH_N, default 2, pulser channel count, range 1..8.
REQ-005 SHALL have parameters PULSER_LEN_W, default 8; DAC_DATA_W, default 10; DAC_GAIN_N, default 32, range 2..64; ACQ_LINES_W, default 5.
REQ-006 SHALL have parameter RD_TIMEOUT, default 64, maximum cycles to wait for RAM read data.
REQ-007 Ports, clock and reset first:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- csr_addr  in  CSR_ADDR_W  CSR address.
- csr_wen  in  1  write strobe.
- csr_wdata  in  CSR_DATA_W  write data.
- csr_ren  in  1  read request, held high until csr_rvalid.
- csr_rvalid  out  1  read data valid, 1-cycle pulse.
- csr_rdata  out  CSR_DATA_W  read data.
- ramctl_raddr  out  RAM_ADDR_W  RAM read address.
- ramctl_ren  out  1  RAM read strobe, 1-cycle pulse.
- ramctl_rvalid  in  1  RAM read data valid.
- ramctl_rdata  in  RAM_DATA_W  RAM read data.
- pulser_on_len  out  CH_N*PULSER_LEN_W  per-channel on length, ch0 in LSBs.
- pulser_off_len  out  CH_N*PULSER_LEN_W  per-channel off length.
- ch_en  out  CH_N  channel enables.
- dac_gain_ptr  in  $clog2(DAC_GAIN_N)  gain table index.
- dac_gain  out  DAC_DATA_W  gain table entry at dac_gain_ptr.
- acq_start  out  1  acquisition start, 1-cycle pulse.
- acq_start_ext  in  1  external start, asynchronous.
- acq_done  in  1  acquisition done pulse.
- acq_busy  in  1  acquisition in progress.
- acq_lines  out  ACQ_LINES_W  lines per acquisition.
- led  out  3  status LEDs.

Function
REQ-008 Address map SHALL be: 0x00 ID, read-only 0xC5A2; 0x01 CTRL [CH_N-1:0] ch_en; 0x02 STATUS, read-only, {rd_timeout_err[2], ext_seen[1], acq_busy[0]}, write 1 to clear bits 2:1; 0x03 ACQLINES; 0x10+ch ON_LEN; 0x18+ch OFF_LEN; 0x20..0x20+DAC_GAIN_N-1 gain table; 0xA0 RAMDATA; 0xA1 RSTRAMADDR; 0xA2 ACQSTART.
REQ-009 Writes SHALL take effect the cycle after csr_wen; writes to unmapped or read-only addresses are ignored; write bits above field width are dropped.
REQ-010 Read FSM SHALL have states IDLE, REG, RAMW, HOLD.
REQ-011 IDLE: on csr_ren with addr != 0xA0, go to REG; with addr == 0xA0, pulse ramctl_ren and go to RAMW.
REQ-012 REG: assert csr_rvalid with register data one cycle after IDLE exit, then go to HOLD. Latency 2 cycles from csr_ren sample; unmapped reads return 0.
REQ-013 RAMW: on ramctl_rvalid, assert csr_rvalid with ramctl_rdata, increment ramctl_raddr (wrapping at 2^RAM_ADDR_W-1 to 0), go to HOLD. After RD_TIMEOUT cycles with no ramctl_rvalid, assert csr_rvalid with 0xDEAD, set rd_timeout_err, leave address unchanged, go to HOLD.
REQ-014 HOLD: ignore csr_ren for exactly one cycle, then go to IDLE, so a master releasing ren one cycle late gets no duplicate read.
REQ-015 Writing RSTRAMADDR SHALL set ramctl_raddr to 0 next cycle. In RAMW the reset is deferred until the read completes.
REQ-016 dac_gain SHALL be registered: gain_table[dac_gain_ptr] appears one cycle after dac_gain_ptr. Pointer values >= DAC_GAIN_N return 0.
REQ-017 Start sources are: a write of bit0=1 to ACQSTART, or a synchronised ext rising edge (REQ-022). A start pulses acq_start one cycle only when acq_busy=0 and no acq_start was issued in the previous cycle. Simultaneous sources produce one pulse. A start while busy is dropped.
REQ-018 led[0] SHALL be set by acq_start and cleared by acq_done; if both occur in the same cycle, set wins. led[1] = rd_timeout_err. led[2] = |ch_en.

Reset
REQ-019 On rst low, all registers SHALL clear asynchronously: csr_rvalid=0, csr_rdata=0, ramctl_ren=0, ramctl_raddr=0, acq_start=0, led=0, ch_en=0, all lengths 0, gain table 0, acq_lines=0, STATUS bits 0, FSM=IDLE.
REQ-020 Reset during RAMW SHALL abort the read, and a late ramctl_rvalid after release SHALL be ignored.
REQ-021 Reset release SHALL be synchronous to clk, through a two-flop release stage.

Configuration
REQ-022 When macro CSR_MC_EXT_START_EN is defined, acq_start_ext SHALL pass through a 2-flop synchroniser and rising-edge detector (3 cycles to acq_start) and set ext_seen. When undefined, acq_start_ext SHALL be ignored and ext_seen SHALL read 0.

Verification
REQ-023 Read 0x00 after reset -> csr_rvalid 2 cycles after ren, data 0xC5A2; read 0x01 -> 0x0000.
REQ-024 Write 0x23=0x0233, set dac_gain_ptr=3 -> dac_gain=0x233 next cycle; read 0x23 -> 0x0233.
REQ-025 RAM model answering 4 cycles after ren with addr+0x42: read 0xA0 three times -> 0x0042, 0x0043, 0x0044; write 0xA1; read 0xA0 -> 0x0042.
REQ-026 RAM model silent -> csr_rvalid after 64 cycles, data 0xDEAD, STATUS=0x0004, led[1]=1; write 0x02=0x0004 -> STATUS=0x0000.
REQ-027 With CSR_MC_EXT_START_EN, 1-cycle acq_start_ext pulse -> one acq_start 3 cycles later, led[0]=1; second pulse while acq_busy=1 -> no acq_start; acq_done -> led[0]=0.
